// File: rtl/sb_split_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sb_split_arbiter
// Purpose  : Round-robin SB bus arbiter with burst hold, locked transfers and
//            RETRY/SPLIT handling. Optional SPLIT masking: SB_ARB_SPLIT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sb_split_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int MIDX_W      = 2
) (
    input  logic                   sb_clk,
    input  logic                   sb_resetn,
    input  logic [NUM_MASTERS-1:0] sb_busreq,
    input  logic [NUM_MASTERS-1:0] sb_lock,
    input  logic [1:0]             sb_trans,
    input  logic [2:0]             sb_burst,
    input  logic                   sb_ready,
    input  logic [1:0]             sb_resp,
    input  logic [NUM_MASTERS-1:0] sb_split,
    output logic [NUM_MASTERS-1:0] sb_grant,
    output logic [MIDX_W-1:0]      sb_master,
    output logic [MIDX_W-1:0]      sb_master_dp,
    output logic                   sb_mastlock,
    output logic [NUM_MASTERS-1:0] sb_split_mask
);

    localparam logic [1:0] c_TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] c_TRANS_SEQ    = 2'b11;
    localparam logic [1:0] c_RESP_SPLIT   = 2'b11;

    typedef enum logic [1:0] {
        ST_ARB    = 2'd0,
        ST_BURST  = 2'd1,
        ST_LOCKED = 2'd2,
        ST_RESP2  = 2'd3
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [2:0]               r_beat_cnt;
    logic [2:0]               w_beat_cnt_nxt;
    logic [NUM_MASTERS-1:0]   r_grant;
    logic [NUM_MASTERS-1:0]   w_grant_nxt;
    logic [MIDX_W-1:0]        r_master;
    logic [MIDX_W-1:0]        w_master_nxt;
    logic [MIDX_W-1:0]        r_master_dp;
    logic                     r_mastlock;
    logic                     w_next_lock;
    logic [NUM_MASTERS-1:0]   r_split_mask;
    logic [NUM_MASTERS-1:0]   w_split_mask_nxt;
    logic [NUM_MASTERS-1:0]   w_elig;
    logic                     w_owner_lock;
    logic                     w_rearb;
    logic                     w_trans_seq;
    logic                     w_burst_start;
    logic                     w_win_found;
    logic [MIDX_W-1:0]        w_win_idx;
    logic [MIDX_W:0]          w_dist;
    logic [MIDX_W:0]          w_best_dist;
    logic                     w_park_found;
    logic [MIDX_W-1:0]        w_park_idx;

    assign w_elig        = sb_busreq & ~r_split_mask;
    assign w_trans_seq   = (sb_trans == c_TRANS_SEQ);
    assign w_burst_start = (sb_trans == c_TRANS_NONSEQ) && (sb_burst != 3'd0);

    always_comb begin
        w_owner_lock = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (r_master == MIDX_W'(i)) begin
                w_owner_lock = sb_lock[i];
            end
        end
    end

    // Distance from the owner in scan order is 1..NUM_MASTERS; the owner itself
    // maps to NUM_MASTERS so it is considered last.
    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = r_master;
        w_dist      = '0;
        w_best_dist = (MIDX_W+1)'(NUM_MASTERS + 1);
        for (int i = 0; i < NUM_MASTERS; i++) begin
            w_dist = ({1'b0, MIDX_W'(i)} + (MIDX_W+1)'(NUM_MASTERS)) - {1'b0, r_master};
            if (w_dist > (MIDX_W+1)'(NUM_MASTERS)) begin
                w_dist = w_dist - (MIDX_W+1)'(NUM_MASTERS);
            end
            if (w_elig[i] && (w_dist < w_best_dist)) begin
                w_best_dist = w_dist;
                w_win_idx   = MIDX_W'(i);
                w_win_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_park_found = 1'b0;
        w_park_idx   = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (!r_split_mask[i]) begin
                w_park_found = 1'b1;
                w_park_idx   = MIDX_W'(i);
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_beat_cnt_nxt = r_beat_cnt;
        w_rearb        = 1'b0;
        if (sb_ready) begin
            case (r_state)
                ST_ARB: begin
                    if (w_burst_start) begin
                        w_beat_cnt_nxt = sb_burst;
                    end
                    if (w_owner_lock) begin
                        w_state_nxt = ST_LOCKED;
                    end else if (w_burst_start) begin
                        w_state_nxt = ST_BURST;
                    end else begin
                        w_state_nxt = ST_ARB;
                        w_rearb     = 1'b1;
                    end
                end
                ST_BURST: begin
                    if (w_trans_seq) begin
                        w_beat_cnt_nxt = r_beat_cnt - 3'd1;
                        if (r_beat_cnt <= 3'd1) begin
                            w_beat_cnt_nxt = '0;
                            w_state_nxt    = ST_ARB;
                            w_rearb        = 1'b1;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (w_burst_start) begin
                        w_beat_cnt_nxt = sb_burst;
                    end else if (w_trans_seq && (r_beat_cnt != 3'd0)) begin
                        w_beat_cnt_nxt = r_beat_cnt - 3'd1;
                    end
                    // Lock released: any remaining beats of the owner's burst still hold the bus.
                    if (!w_owner_lock) begin
                        if (w_beat_cnt_nxt != 3'd0) begin
                            w_state_nxt = ST_BURST;
                        end else begin
                            w_state_nxt = ST_ARB;
                            w_rearb     = 1'b1;
                        end
                    end
                end
                default: begin
                    w_beat_cnt_nxt = '0;
                    w_state_nxt    = ST_ARB;
                    w_rearb        = 1'b1;
                end
            endcase
        end else if (sb_resp[1]) begin
            w_state_nxt    = ST_RESP2;
            w_beat_cnt_nxt = '0;
        end
    end

    always_comb begin
        w_master_nxt = r_master;
        w_grant_nxt  = r_grant;
        if (w_rearb) begin
            if (w_win_found) begin
                w_master_nxt = w_win_idx;
            end else if (w_park_found) begin
                w_master_nxt = w_park_idx;
            end
            for (int i = 0; i < NUM_MASTERS; i++) begin
                w_grant_nxt[i] = (w_master_nxt == MIDX_W'(i)) && (w_win_found || w_park_found);
            end
        end
    end

    always_comb begin
        w_next_lock = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (w_master_nxt == MIDX_W'(i)) begin
                w_next_lock = sb_lock[i] && (w_grant_nxt != '0);
            end
        end
    end

`ifdef SB_ARB_SPLIT_EN
    logic                   w_dp_locked;
    logic [NUM_MASTERS-1:0] w_split_set;

    // A locked data-phase owner is never parked; its SPLIT behaves as RETRY.
    always_comb begin
        w_dp_locked = 1'b0;
        w_split_set = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (r_master_dp == MIDX_W'(i)) begin
                w_dp_locked = sb_lock[i];
            end
        end
        if (!sb_ready && (sb_resp == c_RESP_SPLIT) && (r_state != ST_RESP2) && !w_dp_locked) begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                w_split_set[i] = (r_master_dp == MIDX_W'(i));
            end
        end
    end

    assign w_split_mask_nxt = (r_split_mask & ~sb_split) | w_split_set;
`else
    logic w_unused_split;

    assign w_unused_split   = ^{sb_split, sb_resp[0]};
    assign w_split_mask_nxt = '0;
`endif

    always_ff @(posedge sb_clk or negedge sb_resetn) begin
        if (!sb_resetn) begin
            r_state      <= ST_ARB;
            r_beat_cnt   <= '0;
            r_grant      <= NUM_MASTERS'(1);
            r_master     <= '0;
            r_master_dp  <= '0;
            r_mastlock   <= 1'b0;
            r_split_mask <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_beat_cnt   <= w_beat_cnt_nxt;
            r_split_mask <= w_split_mask_nxt;
            if (sb_ready) begin
                r_grant     <= w_grant_nxt;
                r_master    <= w_master_nxt;
                r_master_dp <= r_master;
                r_mastlock  <= w_next_lock;
            end
        end
    end

    assign sb_grant      = r_grant;
    assign sb_master     = r_master;
    assign sb_master_dp  = r_master_dp;
    assign sb_mastlock   = r_mastlock;
    assign sb_split_mask = r_split_mask;

endmodule
`default_nettype wire

// File: tb/tb_sb_split_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sb_split_arbiter
// Purpose  : Directed and randomized checks of sb_split_arbiter against a
//            behavioural bus-ownership model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sb_split_arbiter;

    localparam int N = 2;
    localparam int W = 2;
`ifdef SB_ARB_SPLIT_EN
    localparam bit c_SPLIT_EN = 1'b1;
`else
    localparam bit c_SPLIT_EN = 1'b0;
`endif

    logic         sb_clk = 1'b0;
    logic         sb_resetn;
    logic [N-1:0] sb_busreq, sb_lock, sb_split;
    logic [1:0]   sb_trans, sb_resp;
    logic [2:0]   sb_burst;
    logic         sb_ready;
    logic [N-1:0] sb_grant, sb_split_mask;
    logic [W-1:0] sb_master, sb_master_dp;
    logic         sb_mastlock;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    always #5 sb_clk = ~sb_clk;

    sb_split_arbiter #(.NUM_MASTERS(N), .MIDX_W(W)) dut (
        .sb_clk        (sb_clk),
        .sb_resetn     (sb_resetn),
        .sb_busreq     (sb_busreq),
        .sb_lock       (sb_lock),
        .sb_trans      (sb_trans),
        .sb_burst      (sb_burst),
        .sb_ready      (sb_ready),
        .sb_resp       (sb_resp),
        .sb_split      (sb_split),
        .sb_grant      (sb_grant),
        .sb_master     (sb_master),
        .sb_master_dp  (sb_master_dp),
        .sb_mastlock   (sb_mastlock),
        .sb_split_mask (sb_split_mask)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit has(input logic [N-1:0] v, input int i);
        return |(v & (N'(1) << i));
    endfunction

    // Next owner: first eligible master after the owner (owner last), else lowest unmasked, else -1.
    function automatic int rr_pick(input int owner, input logic [N-1:0] req, input logic [N-1:0] mask);
        for (int k = 1; k <= N; k++) begin
            if (has(req, (owner + k) % N) && !has(mask, (owner + k) % N)) return (owner + k) % N;
        end
        for (int i = 0; i < N; i++) begin
            if (!has(mask, i)) return i;
        end
        return -1;
    endfunction

    // Behavioural model: ownership is held while beats remain or lock is active.
    logic [N-1:0] m_grant = N'(1);
    logic [N-1:0] m_mask = '0;
    int           m_owner = 0;
    int           m_dp = 0;
    logic         m_mastlock = 1'b0;
    int           m_beats = 0;
    bit           m_in_lock = 1'b0;
    bit           m_in_resp = 1'b0;

    always @(posedge sb_clk or negedge sb_resetn) begin
        if (!sb_resetn) begin
            m_grant    <= N'(1);
            m_owner    <= 0;
            m_dp       <= 0;
            m_mastlock <= 1'b0;
            m_mask     <= '0;
            m_beats    <= 0;
            m_in_lock  <= 1'b0;
            m_in_resp  <= 1'b0;
        end else begin
            automatic int           owner    = m_owner;
            automatic int           beats    = m_beats;
            automatic int           pick     = 0;
            automatic bit           in_lock  = m_in_lock;
            automatic bit           in_resp  = m_in_resp;
            automatic bit           rearb    = 1'b0;
            automatic bit           bursting = (m_beats > 0) && !m_in_lock;
            automatic logic [N-1:0] grant    = m_grant;
            automatic logic [N-1:0] set      = '0;
            if (sb_ready) begin
                if (in_resp) begin
                    in_resp = 1'b0;
                    beats   = 0;
                    rearb   = 1'b1;
                end else begin
                    if (sb_trans == 2'b10 && sb_burst != 0 && !bursting) beats = int'(sb_burst);
                    else if (sb_trans == 2'b11 && beats > 0) beats--;
                    if (bursting) rearb = (beats == 0);
                    else if (!in_lock) begin
                        if (has(sb_lock, owner)) in_lock = 1'b1;
                        else rearb = (beats == 0);
                    end else if (!has(sb_lock, owner)) begin
                        in_lock = 1'b0;
                        rearb   = (beats == 0);
                    end
                end
                if (rearb) begin
                    pick = rr_pick(owner, sb_busreq, m_mask);
                    if (pick >= 0) begin
                        owner = pick;
                        grant = N'(1) << pick;
                    end else begin
                        grant = '0;
                    end
                end
                m_grant    <= grant;
                m_owner    <= owner;
                m_dp       <= m_owner;
                m_mastlock <= (grant != '0) && has(sb_lock, owner);
            end else if (sb_resp[1]) begin
                if (c_SPLIT_EN && !in_resp && sb_resp == 2'b11 && !has(sb_lock, m_dp)) set = N'(1) << m_dp;
                in_resp = 1'b1;
                in_lock = 1'b0;
                beats   = 0;
            end
            m_beats   <= beats;
            m_in_lock <= in_lock;
            m_in_resp <= in_resp;
            m_mask    <= c_SPLIT_EN ? ((m_mask & ~sb_split) | set) : '0;
        end
    end

    always @(negedge sb_clk) begin
        if (cmp_en) begin
            chk("grant", 32'(sb_grant), 32'(m_grant));
            chk("master", 32'(sb_master), 32'(m_owner));
            chk("master_dp", 32'(sb_master_dp), 32'(m_dp));
            chk("mastlock", 32'(sb_mastlock), 32'(m_mastlock));
            chk("split_mask", 32'(sb_split_mask), 32'(m_mask));
        end
    end

    task automatic tick();
        @(posedge sb_clk);
        #1;
    endtask

    task automatic drive(input logic [N-1:0] req, input logic [N-1:0] lck, input logic [1:0] tr,
                         input logic [2:0] bu, input logic rdy, input logic [1:0] rs, input logic [N-1:0] sp);
        sb_busreq = req;
        sb_lock   = lck;
        sb_trans  = tr;
        sb_burst  = bu;
        sb_ready  = rdy;
        sb_resp   = rs;
        sb_split  = sp;
    endtask

    initial begin
        int r;
        sb_resetn = 1'b0;
        drive(2'b00, 2'b00, 2'b00, 3'd0, 1'b1, 2'b00, 2'b00);
        cmp_en = 1'b1;
        tick();
        tick();
        chk("rst_grant", 32'(sb_grant), 32'h1);
        chk("rst_master", 32'(sb_master), 32'h0);
        chk("rst_dp", 32'(sb_master_dp), 32'h0);
        chk("rst_mastlock", 32'(sb_mastlock), 32'h0);
        chk("rst_mask", 32'(sb_split_mask), 32'h0);
        sb_resetn = 1'b1;

        drive(2'b01, 2'b00, 2'b00, 3'd0, 1'b1, 2'b00, 2'b00);
        tick();
        chk("req0_grant", 32'(sb_grant), 32'h1);
        chk("req0_master", 32'(sb_master), 32'h0);

        // Single transfers from two requesters alternate ownership.
        drive(2'b11, 2'b00, 2'b10, 3'd0, 1'b1, 2'b00, 2'b00);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("alt_grant", 32'(sb_grant), (k % 2 == 1) ? 32'h2 : 32'h1);
            chk("alt_dp", 32'(sb_master_dp), (k % 2 == 1) ? 32'h0 : 32'h1);
        end

        // Four-beat burst by M0 with one wait state.
        drive(2'b11, 2'b00, 2'b10, 3'd3, 1'b1, 2'b00, 2'b00);
        tick();
        chk("burst_nonseq", 32'(sb_grant), 32'h1);
        drive(2'b11, 2'b00, 2'b11, 3'd0, 1'b0, 2'b00, 2'b00);
        tick();
        chk("burst_wait", 32'(sb_grant), 32'h1);
        sb_ready = 1'b1;
        tick();
        chk("burst_beat2", 32'(sb_grant), 32'h1);
        tick();
        chk("burst_beat3", 32'(sb_grant), 32'h1);
        tick();
        chk("burst_end_grant", 32'(sb_grant), 32'h2);
        chk("burst_end_master", 32'(sb_master), 32'h1);

        // M1 single transfer, then a two-cycle SPLIT response in its data phase.
        drive(2'b11, 2'b00, 2'b10, 3'd0, 1'b1, 2'b00, 2'b00);
        tick();
        chk("split_dp", 32'(sb_master_dp), 32'h1);
        drive(2'b11, 2'b00, 2'b00, 3'd0, 1'b0, 2'b11, 2'b00);
        tick();
        chk("split_mask_set", 32'(sb_split_mask), c_SPLIT_EN ? 32'h2 : 32'h0);
        sb_ready = 1'b1;
        tick();
        chk("split_grant", 32'(sb_grant), c_SPLIT_EN ? 32'h1 : 32'h2);
        drive(2'b11, 2'b00, 2'b00, 3'd0, 1'b1, 2'b00, 2'b10);
        tick();
        chk("release_mask", 32'(sb_split_mask), 32'h0);
        chk("release_grant", 32'(sb_grant), 32'h1);
        sb_split = 2'b00;
        tick();
        chk("release_m1", 32'(sb_grant), 32'h2);
        tick();
        chk("pre_lock_grant", 32'(sb_grant), 32'h1);

        // Locked sequence by M0 while M1 requests.
        drive(2'b11, 2'b01, 2'b10, 3'd0, 1'b1, 2'b00, 2'b00);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("lock_grant", 32'(sb_grant), 32'h1);
            chk("lock_mastlock", 32'(sb_mastlock), 32'h1);
        end
        drive(2'b11, 2'b00, 2'b10, 3'd0, 1'b0, 2'b00, 2'b00);
        tick();
        chk("unlock_wait_grant", 32'(sb_grant), 32'h1);
        sb_ready = 1'b1;
        tick();
        chk("unlock_grant", 32'(sb_grant), 32'h2);
        chk("unlock_mastlock", 32'(sb_mastlock), 32'h0);

        // Asynchronous reset in the middle of an M1 burst.
        drive(2'b11, 2'b00, 2'b10, 3'd3, 1'b1, 2'b00, 2'b00);
        tick();
        drive(2'b11, 2'b00, 2'b11, 3'd0, 1'b1, 2'b00, 2'b00);
        tick();
        chk("midburst_grant", 32'(sb_grant), 32'h2);
        sb_resetn = 1'b0;
        #2;
        chk("async_rst_grant", 32'(sb_grant), 32'h1);
        chk("async_rst_master", 32'(sb_master), 32'h0);
        chk("async_rst_dp", 32'(sb_master_dp), 32'h0);
        chk("async_rst_mastlock", 32'(sb_mastlock), 32'h0);
        chk("async_rst_mask", 32'(sb_split_mask), 32'h0);
        drive(2'b10, 2'b00, 2'b00, 3'd0, 1'b1, 2'b00, 2'b00);
        tick();
        sb_resetn = 1'b1;
        tick();
        chk("post_rst_grant", 32'(sb_grant), 32'h2);
        chk("post_rst_master", 32'(sb_master), 32'h1);

        // Randomized traffic checked cycle by cycle against the model.
        repeat (3000) begin
            sb_busreq = N'($urandom_range(0, (1 << N) - 1));
            sb_lock   = ($urandom_range(0, 5) == 0) ? N'($urandom_range(0, (1 << N) - 1)) : '0;
            sb_trans  = 2'($urandom_range(0, 3));
            sb_burst  = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
            sb_ready  = ($urandom_range(0, 3) != 0);
            r = int'($urandom_range(0, 15));
            sb_resp   = (r < 12) ? 2'b00 : (r == 12) ? 2'b01 : (r == 13) ? 2'b10 : 2'b11;
            sb_split  = ($urandom_range(0, 7) == 0) ? N'($urandom_range(0, (1 << N) - 1)) : '0;
            tick();
        end

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
